ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch.sv | 126 ++++++++++++
 tb/tb_ifetch.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// ----------------------------------------------------------------------------
// ifetch -- instruction fetch unit with a three-state sequencer.
//
// The unit fetches one instruction word from instruction memory, holds it in
// the instruction register for decode, and on commit computes the next PC.
// Four next-PC sources are supported: pc+4, conditional-branch target, jump
// target and register-indirect target.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rstn         : asynchronous active-low reset
//   imem_req     : fetch request to instruction memory (high in FETCH)
//   imem_addr    : fetch address, always equal to pc
//   imem_ready   : imem_rdata is valid this cycle (used only in FETCH)
//   imem_rdata   : fetched instruction word
//   instr        : instruction register (Op=instr[31:26], Funct=instr[5:0])
//   instr_valid  : instr holds a fetched instruction awaiting commit
//   pc           : address of the instruction in instr
//   pc_plus4     : pc+4, link value for jal/jalr
//   npc_op       : next-PC select: 00 PLUS4, 01 BRANCH, 10 JUMP, 11 JUMPR
//   rs_data      : register target for JUMPR
//   commit       : current instruction retires this cycle (used only in EXEC)
//   misalign     : one-cycle pulse after a JUMPR commit with rs_data[1:0]!=0
//   retired      : count of committed instructions (wraps)
// ----------------------------------------------------------------------------
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [1:0]  npc_op,
    input  logic [31:0] rs_data,
    input  logic        commit,
    output logic        misalign,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10
    } state_t;

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JUMPR  = 2'b11;

    state_t      state;
    logic [31:0] npc;

    // Branch displacement: signed word offset scaled to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        branch_offset = {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    // All additions are plain 32-bit, so overflow wraps modulo 2^32.
    always_comb begin
        npc = pc_plus4;
        case (npc_op)
            NPC_PLUS4:  npc = pc_plus4;
            NPC_BRANCH: npc = pc_plus4 + branch_offset(instr[15:0]);
            NPC_JUMP:   npc = {pc_plus4[31:28], instr[25:0], 2'b00};
            NPC_JUMPR:  npc = {rs_data[31:2], 2'b00};
            default:    npc = pc_plus4;
        endcase
    end

    // imem_req / instr_valid are registered alongside the state so they are
    // glitch-free decodes of the state that will be entered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            misalign    <= 1'b0;
            retired     <= '0;
        end else begin
            // misalign is a single-cycle pulse unless re-armed below
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        state       <= EXEC;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                EXEC: begin
                    if (commit) begin
                        pc          <= npc;
                        retired     <= retired + 32'd1;
                        state       <= FETCH;
                        imem_req    <= 1'b1;
                        instr_valid <= 1'b0;
                        misalign    <= (npc_op == NPC_JUMPR) && (rs_data[1:0] != 2'b00);
                    end
                end
                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// ----------------------------------------------------------------------------
// tb_ifetch -- self-checking bench for ifetch.
//
// dut0 uses the default reset PC and runs a table of fetch/commit vectors;
// expected fetch addresses are queued when a commit is driven and popped when
// the unit raises imem_req. dut1 starts at 0xFFFF_FFFC to exercise PC wrap.
// ----------------------------------------------------------------------------
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rstn;

    logic        imem_req, instr_valid, misalign;
    logic [31:0] imem_addr, instr, pc, pc_plus4, retired;
    logic        imem_ready, commit;
    logic [31:0] imem_rdata, rs_data;
    logic [1:0]  npc_op;

    logic        imem_req1, instr_valid1, misalign1;
    logic [31:0] imem_addr1, instr1, pc1, pc_plus4_1, retired1;
    logic        imem_ready1, commit1;
    logic [31:0] imem_rdata1, rs_data1;
    logic [1:0]  npc_op1;

    always #5 clk = ~clk;

    ifetch dut0 (
        .clk(clk), .rstn(rstn),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4),
        .npc_op(npc_op), .rs_data(rs_data), .commit(commit),
        .misalign(misalign), .retired(retired)
    );

    ifetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rstn(rstn),
        .imem_req(imem_req1), .imem_addr(imem_addr1),
        .imem_ready(imem_ready1), .imem_rdata(imem_rdata1),
        .instr(instr1), .instr_valid(instr_valid1),
        .pc(pc1), .pc_plus4(pc_plus4_1),
        .npc_op(npc_op1), .rs_data(rs_data1), .commit(commit1),
        .misalign(misalign1), .retired(retired1)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  op;
        logic [31:0] rs;
        int          waits;
        int          hold;
        logic [31:0] exp_next;
        logic        exp_mis;
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] exp_q [$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_ret = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20 && imem_req !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        chk("req_seen", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] exp;
        wait_req();
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
            exp = 32'hxxxx_xxxx;
        end else begin
            exp = exp_q.pop_front();
        end
        chk("fetch_addr", imem_addr, exp);
        chk("pc", pc, exp);
        chk("pc_plus4", pc_plus4, exp + 32'd4);
        // wait states, with stray commit pulses that must be ignored
        for (int w = 0; w < v.waits; w++) begin
            imem_ready = 1'b0; commit = 1'b1;
            @(posedge clk); #1;
            chk("wait_addr", imem_addr, exp);
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
            chk("wait_retired", retired, model_ret);
        end
        commit = 1'b0; imem_ready = 1'b1; imem_rdata = v.rdata;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        chk("exec_valid", {31'd0, instr_valid}, 32'd1);
        chk("exec_instr", instr, v.rdata);
        chk("exec_req", {31'd0, imem_req}, 32'd0);
        // stay in EXEC; imem_ready here must be ignored
        for (int h = 0; h < v.hold; h++) begin
            imem_ready = 1'b1; imem_rdata = ~v.rdata;
            @(posedge clk); #1;
            imem_ready = 1'b0;
            chk("hold_instr", instr, v.rdata);
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        end
        commit = 1'b1; npc_op = v.op; rs_data = v.rs;
        model_ret = model_ret + 32'd1;
        exp_q.push_back(v.exp_next);
        @(posedge clk); #1;
        commit = 1'b0; npc_op = 2'b11; rs_data = 32'hFFFF_FFFF;
        chk("misalign", {31'd0, misalign}, {31'd0, v.exp_mis});
        chk("retired", retired, model_ret);
        chk("post_valid", {31'd0, instr_valid}, 32'd0);
        if (v.exp_mis) begin
            @(posedge clk); #1;
            chk("misalign_off", {31'd0, misalign}, 32'd0);
        end
    endtask

    initial begin
        vecs[0]  = '{32'h2001_0001, 2'b00, 32'hDEAD_BEEF, 0, 0, 32'h0000_0004, 1'b0};
        vecs[1]  = '{32'h0000_0000, 2'b00, 32'hDEAD_BEEF, 0, 2, 32'h0000_0008, 1'b0};
        vecs[2]  = '{32'h0000_0000, 2'b00, 32'h0000_0003, 0, 0, 32'h0000_000C, 1'b0};
        vecs[3]  = '{32'h0000_0000, 2'b00, 32'h0000_0000, 3, 0, 32'h0000_0010, 1'b0};
        vecs[4]  = '{32'h1000_FFFE, 2'b01, 32'hDEAD_BEEF, 0, 0, 32'h0000_000C, 1'b0};
        vecs[5]  = '{32'h0000_0000, 2'b00, 32'h0000_0000, 0, 0, 32'h0000_0010, 1'b0};
        vecs[6]  = '{32'h1000_0003, 2'b01, 32'h0000_0001, 0, 0, 32'h0000_0020, 1'b0};
        vecs[7]  = '{32'h0000_0000, 2'b11, 32'h1000_0000, 0, 0, 32'h1000_0000, 1'b0};
        vecs[8]  = '{32'h0800_0040, 2'b10, 32'h0000_0002, 0, 0, 32'h1000_0100, 1'b0};
        vecs[9]  = '{32'h0000_0000, 2'b11, 32'h0000_3006, 0, 0, 32'h0000_3004, 1'b1};
        vecs[10] = '{32'h0BFF_FFFF, 2'b10, 32'h0000_0000, 1, 0, 32'h0FFF_FFFC, 1'b0};
        vecs[11] = '{32'h0000_0000, 2'b00, 32'h0000_0000, 0, 0, 32'h1000_0000, 1'b0};

        rstn = 1'b0;
        imem_ready = 1'b0; commit = 1'b0; imem_rdata = '0; rs_data = '0; npc_op = 2'b00;
        imem_ready1 = 1'b0; commit1 = 1'b0; imem_rdata1 = 32'h1234_5678; rs_data1 = '0; npc_op1 = 2'b00;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_pc1", pc1, 32'hFFFF_FFFC);

        rstn = 1'b1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk); #1;
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        exp_q.push_back(32'h0);

        // wrap: dut1 fetches at 0xFFFF_FFFC, commits PLUS4 -> 0x0
        chk("wrap_req", {31'd0, imem_req1}, 32'd1);
        chk("wrap_addr", imem_addr1, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4_1, 32'h0);
        imem_ready1 = 1'b1;
        @(posedge clk); #1;
        imem_ready1 = 1'b0; commit1 = 1'b1;
        @(posedge clk); #1;
        commit1 = 1'b0;
        chk("wrap_next", imem_addr1, 32'h0);
        chk("wrap_retired", retired1, 32'd1);
        chk("dut0_waiting", {31'd0, instr_valid}, 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // reset while holding an instruction in EXEC
        wait_req();
        chk("pre_rst_addr", imem_addr, exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxx_xxxx);
        imem_ready = 1'b1; imem_rdata = 32'h2010_0005;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        chk("pre_rst_instr", instr, 32'h2010_0005);
        commit = 1'b1;
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_instr", instr, 32'h0);
        chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("mid_rst_pc", pc, 32'h0);
        @(posedge clk); #1;
        commit = 1'b0;
        chk("mid_rst_retired", retired, 32'h0);
        rstn = 1'b1;
        chk("rel_req0", {31'd0, imem_req}, 32'd0);
        @(posedge clk); #1;
        chk("rel_req1", {31'd0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
